// File: rtl/shot_clock_ctrl.sv
// Basket-shot arcade controller: debounced hoop sensor, per-second game
// timer, saturating score and a one-cycle game_over leaderboard strobe.
module shot_clock_ctrl #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned GAME_SECONDS    = 30,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hoop_switch,
  output logic [7:0] time_left,
  output logic [7:0] score,
  output logic       running,
  output logic       game_over,
  output logic [7:0] final_score
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         GAME_TIME  = 8'(GAME_SECONDS);
  localparam logic [7:0]         SCORE_MAX  = 8'd99;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db_level;
  logic [DB_W-1:0]    r_db_cnt;
  logic [1:0]         r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_time;
  logic [7:0]         r_score;
  logic [7:0]         r_final;
  logic               r_running;
  logic               r_game_over;

  logic               w_db_diff;
  logic               w_db_flip;
  logic               w_basket;
  logic               w_db_level_nxt;
  logic [DB_W-1:0]    w_db_cnt_nxt;
  logic [1:0]         w_state_nxt;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic [7:0]         w_time_nxt;
  logic [7:0]         w_score_nxt;
  logic [7:0]         w_final_nxt;
  logic               w_running_nxt;
  logic               w_game_over_nxt;

  // Debounce qualifiers: a flip needs DEBOUNCE_CYCLES consecutive differing cycles
  assign w_db_diff = r_sync2 ^ r_db_level;
  assign w_db_flip = w_db_diff && (r_db_cnt == DB_LAST);
  assign w_basket  = w_db_flip && r_sync2;

  // Two-flop synchronizer for the asynchronous hoop sensor
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= hoop_switch;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic for debouncer, game FSM, timer and score
  always_comb begin
    w_db_level_nxt  = r_db_level;
    w_db_cnt_nxt    = r_db_cnt;
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_time_nxt      = r_time;
    w_score_nxt     = r_score;
    w_final_nxt     = r_final;
    w_game_over_nxt = 1'b0;

    // Debouncer runs in every state so a ball held in the beam at start is not counted
    if (!w_db_diff || w_db_flip) begin
      w_db_cnt_nxt = '0;
    end else begin
      w_db_cnt_nxt = r_db_cnt + DB_W'(1);
    end
    if (w_db_flip) begin
      w_db_level_nxt = r_sync2;
    end

    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_presc_nxt = '0;
          w_time_nxt  = GAME_TIME;
          w_score_nxt = 8'd0;
        end
      end
      S_RUN: begin
        if (w_basket && (r_score < SCORE_MAX)) begin
          w_score_nxt = r_score + 8'd1;
        end
        if (r_presc == PRESC_LAST) begin
          w_presc_nxt = '0;
          if (r_time != 8'd0) begin
            w_time_nxt = r_time - 8'd1;
          end
          // Final tick: a basket landing on this same edge is included
          if (r_time <= 8'd1) begin
            w_state_nxt     = S_OVER;
            w_game_over_nxt = 1'b1;
            w_final_nxt     = w_score_nxt;
          end
        end else begin
          w_presc_nxt = r_presc + PRESC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_running_nxt = (w_state_nxt == S_RUN);
  end

  // State and output registers; reset overrides start, baskets and ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      r_db_level  <= 1'b0;
      r_db_cnt    <= '0;
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_time      <= GAME_TIME;
      r_score     <= 8'd0;
      r_final     <= 8'd0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_db_level  <= w_db_level_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_time      <= w_time_nxt;
      r_score     <= w_score_nxt;
      r_final     <= w_final_nxt;
      r_running   <= w_running_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign time_left   = r_time;
  assign score       = r_score;
  assign running     = r_running;
  assign game_over   = r_game_over;
  assign final_score = r_final;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Testbench for shot_clock_ctrl: a 3-second instance for the timing scenarios
// and a 150-second instance for multi-basket and saturation scenarios.
module tb_shot_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, hoop;
  logic [7:0] tl, sc, fs;
  logic       run, go;
  logic       rst_l, start_l, hoop_l;
  logic [7:0] tl_l, sc_l, fs_l;
  logic       run_l, go_l;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ql[$];
  logic [7:0] exp_fs, exp_fsl;

  shot_clock_ctrl #(.CLK_HZ(10), .GAME_SECONDS(3), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clk), .reset(rst), .start(start), .hoop_switch(hoop),
    .time_left(tl), .score(sc), .running(run), .game_over(go), .final_score(fs));

  shot_clock_ctrl #(.CLK_HZ(10), .GAME_SECONDS(150), .DEBOUNCE_CYCLES(4)) dut_l (
    .clock(clk), .reset(rst_l), .start(start_l), .hoop_switch(hoop_l),
    .time_left(tl_l), .score(sc_l), .running(run_l), .game_over(go_l), .final_score(fs_l));

  always #5 clk = ~clk;

  // Scoreboard: every game_over pops the final score queued when the game was started
  always begin
    @(posedge clk); #1;
    if (go === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_unexpected_game_over: got game_over=1 final=%0d required no pulse", fs);
      end else begin
        exp_fs = exp_q.pop_front();
        if (fs !== exp_fs) begin
          n_err++; $display("FAIL sb_final_score: got %0d required %0d", fs, exp_fs);
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (go_l === 1'b1) begin
      n_vec++;
      if (exp_ql.size() == 0) begin
        n_err++; $display("FAIL sbl_unexpected_game_over: got game_over=1 final=%0d required no pulse", fs_l);
      end else begin
        exp_fsl = exp_ql.pop_front();
        if (fs_l !== exp_fsl) begin
          n_err++; $display("FAIL sbl_final_score: got %0d required %0d", fs_l, exp_fsl);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 3-second game with no baskets, checking the timer cycle by cycle
  task automatic play_full_game(input logic [7:0] exp_final);
    int e;
    exp_q.push_back(exp_final);
    start = 1'b1; tick(1); start = 1'b0;
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) tick(1);
      e = (c >= 30) ? 0 : 3 - c / 10;
      n_vec++;
      if (tl !== 8'(e) || run !== (c < 30) || go !== (c == 30) || sc !== 8'd0) begin
        n_err++;
        $display("FAIL game_timeline c=%0d: got tl=%0d run=%b go=%b sc=%0d required tl=%0d run=%b go=%b sc=0",
                 c, tl, run, go, sc, e, (c < 30), (c == 30));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_l = 1'b1; tick(2);
    n_vec++; if (tl !== 8'd3) begin n_err++; $display("FAIL reset_time_left: got %0d required 3", tl); end
    n_vec++; if (sc !== 8'd0) begin n_err++; $display("FAIL reset_score: got %0d required 0", sc); end
    n_vec++; if (fs !== 8'd0) begin n_err++; $display("FAIL reset_final: got %0d required 0", fs); end
    n_vec++; if (run !== 1'b0 || go !== 1'b0) begin n_err++; $display("FAIL reset_flags: got run=%b go=%b required 0 0", run, go); end
    n_vec++; if (tl_l !== 8'd150 || sc_l !== 8'd0) begin n_err++; $display("FAIL reset_long: got tl=%0d sc=%0d required 150 0", tl_l, sc_l); end
    rst = 1'b0; rst_l = 1'b0;
    // Basket while idle is discarded
    hoop = 1'b1; tick(8); hoop = 1'b0; tick(8);
    n_vec++; if (sc !== 8'd0 || run !== 1'b0 || tl !== 8'd3) begin
      n_err++; $display("FAIL idle_basket: got sc=%0d run=%b tl=%0d required 0 0 3", sc, run, tl);
    end
  endtask

  task automatic test_basic_game;
    play_full_game(8'd0);
  endtask

  task automatic test_glitches;
    exp_q.push_back(8'd1);
    start = 1'b1; tick(1); start = 1'b0;
    hoop = 1'b1; tick(1); hoop = 1'b0; tick(4);
    hoop = 1'b1; tick(2); hoop = 1'b0; tick(4);
    hoop = 1'b1; tick(3); hoop = 1'b0; tick(4);
    n_vec++; if (sc !== 8'd0) begin n_err++; $display("FAIL glitch_rejected: got %0d required 0", sc); end
    hoop = 1'b1; tick(10);
    n_vec++; if (sc !== 8'd1 || run !== 1'b1) begin n_err++; $display("FAIL held_pulse: got sc=%0d run=%b required 1 1", sc, run); end
    tick(2);
    n_vec++; if (go !== 1'b1) begin n_err++; $display("FAIL glitch_game_end: got go=%b required 1", go); end
    tick(10); hoop = 1'b0; tick(8);
    n_vec++; if (sc !== 8'd1) begin n_err++; $display("FAIL glitch_after: got %0d required 1", sc); end
  endtask

  task automatic test_final_tick;
    exp_q.push_back(8'd1);
    start = 1'b1; tick(1); start = 1'b0;
    tick(24); hoop = 1'b1; tick(5);
    n_vec++; if (sc !== 8'd0 || tl !== 8'd1) begin n_err++; $display("FAIL pre_final_tick: got sc=%0d tl=%0d required 0 1", sc, tl); end
    tick(1);
    n_vec++; if (sc !== 8'd1 || fs !== 8'd1 || go !== 1'b1 || tl !== 8'd0 || run !== 1'b0) begin
      n_err++; $display("FAIL final_tick_basket: got sc=%0d fs=%0d go=%b tl=%0d run=%b required 1 1 1 0 0", sc, fs, go, tl, run);
    end
    tick(4); hoop = 1'b0; tick(8);
    hoop = 1'b1; tick(10); hoop = 1'b0; tick(8);
    n_vec++; if (sc !== 8'd1 || fs !== 8'd1 || tl !== 8'd0 || run !== 1'b0) begin
      n_err++; $display("FAIL over_basket: got sc=%0d fs=%0d tl=%0d run=%b required 1 1 0 0", sc, fs, tl, run);
    end
  endtask

  task automatic test_reset_mid_run;
    int bad;
    start = 1'b1; tick(1); start = 1'b0;
    hoop = 1'b1; tick(6); hoop = 1'b0; tick(6);
    hoop = 1'b1; tick(6); hoop = 1'b0; tick(2);
    n_vec++; if (sc !== 8'd2 || run !== 1'b1) begin n_err++; $display("FAIL midrun_score: got sc=%0d run=%b required 2 1", sc, run); end
    rst = 1'b1; tick(1);
    n_vec++; if (tl !== 8'd3 || sc !== 8'd0 || fs !== 8'd0 || run !== 1'b0 || go !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset: got tl=%0d sc=%0d fs=%0d run=%b go=%b required 3 0 0 0 0", tl, sc, fs, run, go);
    end
    tick(1); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (go !== 1'b0 || run !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL abandoned_quiet: got %0d active cycles required 0", bad); end
    play_full_game(8'd0);
  endtask

  task automatic test_clean_pulses;
    exp_ql.push_back(8'd3);
    start_l = 1'b1; tick(1); start_l = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hoop_l = 1'b1; tick(8); hoop_l = 1'b0; tick(10);
      n_vec++; if (sc_l !== 8'(k + 1)) begin n_err++; $display("FAIL clean_pulse_%0d: got %0d required %0d", k, sc_l, k + 1); end
    end
    tick(1500 - 54 - 1);
    n_vec++; if (go_l !== 1'b0 || tl_l !== 8'd1 || run_l !== 1'b1) begin
      n_err++; $display("FAIL long_pre_end: got go=%b tl=%0d run=%b required 0 1 1", go_l, tl_l, run_l);
    end
    tick(1);
    n_vec++; if (go_l !== 1'b1 || tl_l !== 8'd0 || fs_l !== 8'd3 || run_l !== 1'b0) begin
      n_err++; $display("FAIL long_end: got go=%b tl=%0d fs=%0d run=%b required 1 0 3 0", go_l, tl_l, fs_l, run_l);
    end
  endtask

  task automatic test_saturate;
    int bad;
    exp_ql.push_back(8'd99);
    start_l = 1'b1; tick(1); start_l = 1'b0;
    n_vec++; if (sc_l !== 8'd0 || tl_l !== 8'd150 || run_l !== 1'b1 || fs_l !== 8'd3) begin
      n_err++; $display("FAIL restart_from_over: got sc=%0d tl=%0d run=%b fs=%0d required 0 150 1 3", sc_l, tl_l, run_l, fs_l);
    end
    bad = 0;
    for (int i = 0; i < 101; i++) begin
      hoop_l = 1'b1; tick(6); hoop_l = 1'b0; tick(6);
      if (sc_l !== 8'((i + 1 > 99) ? 99 : i + 1)) begin
        bad++;
        $display("FAIL saturate_step_%0d: got %0d required %0d", i, sc_l, (i + 1 > 99) ? 99 : i + 1);
      end
    end
    n_vec++; if (bad != 0) n_err++;
    start_l = 1'b1; tick(20); start_l = 1'b0;
    n_vec++; if (tl_l !== 8'd27 || sc_l !== 8'd99 || run_l !== 1'b1) begin
      n_err++; $display("FAIL start_in_run: got tl=%0d sc=%0d run=%b required 27 99 1", tl_l, sc_l, run_l);
    end
    tick(1500 - 1232);
    n_vec++; if (go_l !== 1'b1 || fs_l !== 8'd99 || tl_l !== 8'd0) begin
      n_err++; $display("FAIL saturate_end: got go=%b fs=%0d tl=%0d required 1 99 0", go_l, fs_l, tl_l);
    end
    start_l = 1'b1; tick(1); start_l = 1'b0;
    n_vec++; if (sc_l !== 8'd0 || tl_l !== 8'd150 || run_l !== 1'b1 || fs_l !== 8'd99 || go_l !== 1'b0) begin
      n_err++; $display("FAIL start_after_sat: got sc=%0d tl=%0d run=%b fs=%0d go=%b required 0 150 1 99 0",
                        sc_l, tl_l, run_l, fs_l, go_l);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hoop = 1'b0;
    rst_l = 1'b1; start_l = 1'b0; hoop_l = 1'b0;
    test_reset();
    test_basic_game();
    test_glitches();
    test_final_tick();
    test_reset_mid_run();
    test_clean_pulses();
    test_saturate();
    tick(3);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_pending: got %0d unmatched games required 0", exp_q.size()); end
    n_vec++; if (exp_ql.size() != 0) begin n_err++; $display("FAIL sbl_pending: got %0d unmatched games required 0", exp_ql.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
